// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, plus single-cycle MTHI/MTLO writes.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      MdOp,
    input  logic [XLEN-1:0] DataIn1,
    input  logic [XLEN-1:0] DataIn2,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              signed_op;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign signed_op = (MdOp == 3'd0) || (MdOp == 3'd2);
    assign a_neg     = signed_op && DataIn1[XLEN-1];
    assign b_neg     = signed_op && DataIn2[XLEN-1];
    assign a_mag     = a_neg ? -DataIn1 : DataIn1;
    assign b_mag     = b_neg ? -DataIn2 : DataIn2;

    // Multiply: high half accumulates, multiplier bits drain out of the low half.
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: remainder in the high half, dividend shifts up and quotient bits fill in below.
    assign div_shift = prod_q[2*XLEN-1:XLEN-1];
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

    assign prod_fix  = neg_res_q ? -prod_q : prod_q;
    assign quo_fix   = (neg_res_q && !div0_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix   = neg_rem_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && !Flush) begin
                    case (MdOp)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = MdOp[1];
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = MdOp[1] && (DataIn2 == '0);
                            opnd_d    = MdOp[1] ? b_mag : a_mag;
                            prod_d    = {{XLEN{1'b0}}, (MdOp[1] ? a_mag : b_mag)};
                            cnt_d     = '0;
                            state_d   = CALC;
                        end
                        3'd4:    hi_d = DataIn1;
                        3'd5:    lo_d = DataIn1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (Flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = is_div_q ? {(div_ge ? div_diff : div_shift[XLEN-1:0]),
                                         prod_q[XLEN-2:0], div_ge}
                                      : {mul_sum, prod_q[XLEN-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!Flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign state_dbg = state_q;

endmodule
